// File: rtl/gate_pair_checker.sv
// Exhaustive self-test sequencer for an AND/OR gate pair: drives {a,b}=00..11, samples after a
// settle delay, counts mismatching vectors. Define GATE_PAIR_CHECKER_STOP_ON_ERR_EN to abort on the first mismatch.
module gate_pair_checker #(
  parameter int SETTLE_CYCLES = 1,
  parameter int PASSES        = 1,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a_o,
  output logic             b_o,
  input  logic             and_i,
  input  logic             or_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       vec_idx
);

  localparam int CW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES);
  localparam logic [PW-1:0] LAST_PASS = PW'(PASSES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       vec_q, vec_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             mismatch;

  // One error per vector, regardless of whether one or both gates disagree.
  assign mismatch = (and_i != (vec_q[1] & vec_q[0])) || (or_i != (vec_q[1] | vec_q[0]));

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    pcnt_d  = pcnt_q;
    err_d   = err_q;
    pass_d  = pass_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_DRIVE;
          vec_d   = 2'd0;
          err_d   = '0;
          pcnt_d  = '0;
          pass_d  = 1'b0;
        end
      end
      S_DRIVE: begin
        cnt_d   = SETTLE_LD;
        state_d = (SETTLE_CYCLES > 0) ? S_SETTLE : S_CHECK;
      end
      S_SETTLE: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (mismatch && (err_q != {ERR_W{1'b1}})) err_d = err_q + ERR_W'(1);
`ifdef GATE_PAIR_CHECKER_STOP_ON_ERR_EN
        if (mismatch) begin
          state_d = S_DONE;
        end else
`endif
        if (vec_q != 2'd3) begin
          vec_d   = vec_q + 2'd1;
          state_d = S_DRIVE;
        end else if (pcnt_q != LAST_PASS) begin
          vec_d   = 2'd0;
          pcnt_d  = pcnt_q + PW'(1);
          state_d = S_DRIVE;
        end else begin
          state_d = S_DONE;
        end
        if (state_d == S_DONE) pass_d = (err_d == '0);
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so every port comes straight off a flop.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    if (state_d == S_DRIVE || state_d == S_SETTLE || state_d == S_CHECK) begin
      a_d = vec_d[1];
      b_d = vec_d[0];
    end else begin
      a_d = 1'b0;
      b_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q   <= 2'd0;
      cnt_q   <= '0;
      pcnt_q  <= '0;
      err_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      err_q   <= err_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign a_o       = a_q;
  assign b_o       = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign vec_idx   = vec_q;

endmodule

// File: tb/tb_gate_pair_checker.sv
// Scoreboard bench: three checker configurations against behavioural gate models with injectable faults.
module tb_gate_pair_checker;

`ifdef GATE_PAIR_CHECKER_STOP_ON_ERR_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  typedef struct {
    int dut;
    int err;
    int pss;
    int vec;
    int lat;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [2:0] start, a_o, b_o, and_i, or_i, busy, done, pass;
  logic [1:0] fmode [3];
  logic [1:0] vidx  [3];
  logic [7:0] err_a, err_b;
  logic [0:0] err_c;

  exp_t sb[$];
  int   nchk = 0;
  int   errors = 0;
  int   cyc   [3];
  bit   bprev [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gate models: 0 = correct, 1 = outputs swapped, 2 = or output stuck at 0
  for (genvar g = 0; g < 3; g++) begin : g_gate
    assign and_i[g] = (fmode[g] == 2'd1) ? (a_o[g] | b_o[g]) : (a_o[g] & b_o[g]);
    assign or_i[g]  = (fmode[g] == 2'd1) ? (a_o[g] & b_o[g]) :
                      (fmode[g] == 2'd2) ? 1'b0 : (a_o[g] | b_o[g]);
  end

  gate_pair_checker #(.SETTLE_CYCLES(1), .PASSES(1), .ERR_W(8)) u_a (
    .clk(clk), .rst(rst), .start(start[0]), .a_o(a_o[0]), .b_o(b_o[0]),
    .and_i(and_i[0]), .or_i(or_i[0]), .busy(busy[0]), .done(done[0]),
    .pass(pass[0]), .err_count(err_a), .vec_idx(vidx[0]));

  gate_pair_checker #(.SETTLE_CYCLES(1), .PASSES(2), .ERR_W(8)) u_b (
    .clk(clk), .rst(rst), .start(start[1]), .a_o(a_o[1]), .b_o(b_o[1]),
    .and_i(and_i[1]), .or_i(or_i[1]), .busy(busy[1]), .done(done[1]),
    .pass(pass[1]), .err_count(err_b), .vec_idx(vidx[1]));

  gate_pair_checker #(.SETTLE_CYCLES(0), .PASSES(2), .ERR_W(1)) u_c (
    .clk(clk), .rst(rst), .start(start[2]), .a_o(a_o[2]), .b_o(b_o[2]),
    .and_i(and_i[2]), .or_i(or_i[2]), .busy(busy[2]), .done(done[2]),
    .pass(pass[2]), .err_count(err_c), .vec_idx(vidx[2]));

  task automatic check(input string nm, input int act, input int exp_v);
    nchk++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic push(input int d, input int e, input int p, input int v, input int l);
    exp_t x;
    x.dut = d; x.err = e; x.pss = p; x.vec = v; x.lat = l;
    sb.push_back(x);
  endtask

  task automatic pulse_start(input int i);
    @(negedge clk);
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int k;
    k = 0;
    while (busy[i] && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) check("run_timeout", 1, 0);
  endtask

  // Monitor: latency counted from the first busy cycle; done pops the scoreboard
  initial begin
    exp_t x;
    int   e;
    for (int i = 0; i < 3; i++) begin
      cyc[i] = 0;
      bprev[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (busy[i] && !bprev[i]) cyc[i] = 1;
        else if (busy[i]) cyc[i]++;
        bprev[i] = busy[i];
        if (done[i] === 1'b1) begin
          case (i)
            0:       e = int'(err_a);
            1:       e = int'(err_b);
            default: e = int'(err_c);
          endcase
          if (sb.size() == 0 || sb[0].dut != i) begin
            check($sformatf("unexpected_done_dut%0d", i), 1, 0);
          end else begin
            x = sb.pop_front();
            check($sformatf("err_count_dut%0d", i), e, x.err);
            check($sformatf("pass_dut%0d", i), int'(pass[i]), x.pss);
            check($sformatf("vec_idx_dut%0d", i), int'(vidx[i]), x.vec);
            check($sformatf("done_latency_dut%0d", i), cyc[i], x.lat);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int k;
    rst   = 1'b1;
    start = '0;
    for (int i = 0; i < 3; i++) fmode[i] = 2'd0;
    repeat (3) @(negedge clk);
    check("rst_a_o", int'(a_o[0]), 0);
    check("rst_b_o", int'(b_o[0]), 0);
    check("rst_busy", int'(busy[0]), 0);
    check("rst_done", int'(done[0]), 0);
    check("rst_pass", int'(pass[0]), 0);
    check("rst_err", int'(err_a), 0);
    check("rst_vec", int'(vidx[0]), 0);
    check("rst_busy_bc", int'(busy[2:1]), 0);
    rst = 1'b0;

    // Clean sweep with per-cycle stimulus trace
    push(0, 0, 1, 3, 13);
    pulse_start(0);
    for (int j = 0; j < 12; j++) begin
      check($sformatf("trace_ab_c%0d", j), int'({a_o[0], b_o[0]}), j / 3);
      @(negedge clk);
    end
    check("done_ab", int'({a_o[0], b_o[0]}), 0);
    check("done_busy", int'(busy[0]), 1);
    @(negedge clk);
    check("busy_fall", int'(busy[0]), 0);
    repeat (3) @(negedge clk);
    check("pass_held", int'(pass[0]), 1);

    // Swapped outputs: vectors 01 and 10 disagree
    fmode[0] = 2'd1;
    if (STOP) push(0, 1, 0, 1, 7); else push(0, 2, 0, 3, 13);
    pulse_start(0);
    wait_idle(0);

    // or output stuck at 0: vectors 01, 10, 11 disagree
    fmode[0] = 2'd2;
    if (STOP) push(0, 1, 0, 1, 7); else push(0, 3, 0, 3, 13);
    pulse_start(0);
    wait_idle(0);

    // Reset during vector 2 settle: no done, everything back to reset values
    fmode[0] = 2'd0;
    pulse_start(0);
    repeat (7) @(negedge clk);
    check("pre_rst_vec", int'(vidx[0]), 2);
    check("pre_rst_ab", int'({a_o[0], b_o[0]}), 2);
    rst = 1'b1;
    #1;
    check("midrst_busy", int'(busy[0]), 0);
    check("midrst_ab", int'({a_o[0], b_o[0]}), 0);
    check("midrst_done", int'(done[0]), 0);
    check("midrst_pass", int'(pass[0]), 0);
    check("midrst_vec", int'(vidx[0]), 0);
    @(negedge clk);
    rst = 1'b0;

    // Clean sweep with a stray start pulse mid-run
    push(0, 0, 1, 3, 13);
    pulse_start(0);
    repeat (4) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_idle(0);

    // start held high: back-to-back runs with a single idle cycle between
    push(0, 0, 1, 3, 13);
    push(0, 0, 1, 3, 13);
    @(negedge clk);
    start[0] = 1'b1;
    k = 0;
    while (done[0] !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) check("held_timeout", 1, 0);
    @(negedge clk);
    check("held_idle_gap", int'(busy[0]), 0);
    @(negedge clk);
    check("held_restart", int'(busy[0]), 1);
    start[0] = 1'b0;
    wait_idle(0);

    // Two passes, or stuck at 0
    fmode[1] = 2'd2;
    if (STOP) push(1, 1, 0, 1, 7); else push(1, 6, 0, 3, 25);
    pulse_start(1);
    wait_idle(1);

    // One-bit error counter saturates, zero settle, two passes
    fmode[2] = 2'd1;
    if (STOP) push(2, 1, 0, 1, 5); else push(2, 1, 0, 3, 17);
    pulse_start(2);
    wait_idle(2);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, nchk);
    $finish;
  end

endmodule
